// File: rtl/foxtrot_pkg.sv
// Shared types and helpers for the ROB completion arbiter.
// Optional perf counters are enabled with `ROB_ARB_PERF_EN.
package foxtrot_pkg;

    localparam int DEF_INST_ID_BITS = 6;

    typedef logic [DEF_INST_ID_BITS-1:0] inst_id_t;

    // Pointer width with one extra wrap bit for full/empty detection.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/completion_fifo.sv
// Per-FU completion FIFO with wrap-bit pointers.
// Flush empties it; no bypass from push to head.
import foxtrot_pkg::*;

module completion_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset and flush both drop every entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full && !rst && !flush)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rob_completion_arbiter.sv
// Round-robin merge of FU completions onto the ROB ports.
// `ROB_ARB_PERF_EN adds saturating grant/stall counters.
import foxtrot_pkg::*;

module rob_completion_arbiter #(
    parameter int INST_ID_BITS = DEF_INST_ID_BITS,
    parameter int FU_COUNT     = 4,
    parameter int COMMIT_PORTS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic [FU_COUNT-1:0] fu_valid,
    output logic [FU_COUNT-1:0] fu_ready,
    input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_inst_id,
    output logic [COMMIT_PORTS-1:0] rob_valid,
    output logic [COMMIT_PORTS-1:0][INST_ID_BITS-1:0] rob_inst_id
`ifdef ROB_ARB_PERF_EN
    ,
    output logic [31:0] perf_grants,
    output logic [31:0] perf_stalls
`endif
);

    localparam int RW = $clog2(FU_COUNT);

    logic [RW-1:0]           rr_ptr;
    logic [RW-1:0]           rr_nxt;
    logic [FU_COUNT-1:0]     full;
    logic [FU_COUNT-1:0]     empty;
    logic [FU_COUNT-1:0]     push;
    logic [FU_COUNT-1:0]     grant;
    logic [INST_ID_BITS-1:0] head [FU_COUNT];
    logic [COMMIT_PORTS-1:0] pv;
    logic [COMMIT_PORTS-1:0][INST_ID_BITS-1:0] pid;

    assign fu_ready = ~full;
    assign push     = fu_valid & ~full;

    for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
        completion_fifo #(
            .DEPTH(FIFO_DEPTH),
            .WIDTH(INST_ID_BITS)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .flush(flush),
            .push (push[g]),
            .din  (fu_inst_id[g]),
            .full (full[g]),
            .pop  (grant[g]),
            .empty(empty[g]),
            .head (head[g])
        );
    end

    // Scan from rr_ptr; k-th non-empty FU goes to port k.
    always_comb begin
        int cnt;
        int j;
        int last;
        grant  = '0;
        pv     = '0;
        pid    = '0;
        cnt    = 0;
        last   = 0;
        rr_nxt = rr_ptr;
        for (int k = 0; k < FU_COUNT; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= FU_COUNT)
                j = j - FU_COUNT;
            if (!empty[j] && cnt < COMMIT_PORTS) begin
                grant[j] = 1'b1;
                pv[cnt]  = 1'b1;
                pid[cnt] = head[j];
                cnt      = cnt + 1;
                last     = j;
            end
        end
        if (cnt != 0)
            rr_nxt = (last == FU_COUNT - 1) ? '0 : RW'(last + 1);
    end

    // Output registers and pointer; flush blanks ports, holds rr_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rob_valid   <= '0;
            rob_inst_id <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            rob_valid <= '0;
        end else begin
            rob_valid   <= pv;
            rob_inst_id <= pid;
            rr_ptr      <= rr_nxt;
        end
    end

`ifdef ROB_ARB_PERF_EN
    logic [31:0] n_gr;
    logic [32:0] gr_sum;

    assign n_gr   = 32'($countones(grant));
    assign gr_sum = {1'b0, perf_grants} + {1'b0, n_gr};

    // Saturating counters; flush only suppresses forwarded grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (!flush)
                perf_grants <= gr_sum[32] ? '1 : gr_sum[31:0];
            if (|(fu_valid & ~fu_ready) && perf_stalls != '1)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// Directed self-checking bench for rob_completion_arbiter.
// Default build; perf checks compile in with `ROB_ARB_PERF_EN.
module tb_rob_completion_arbiter;

    localparam int IW = 6;
    localparam int FC = 4;
    localparam int CP = 2;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [FC-1:0] fu_valid;
    logic [FC-1:0] fu_ready;
    logic [FC-1:0][IW-1:0] fu_inst_id;
    logic [CP-1:0] rob_valid;
    logic [CP-1:0][IW-1:0] rob_inst_id;
`ifdef ROB_ARB_PERF_EN
    logic [31:0] perf_grants;
    logic [31:0] perf_stalls;
`endif

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    rob_completion_arbiter #(
        .INST_ID_BITS(IW),
        .FU_COUNT(FC),
        .COMMIT_PORTS(CP),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .fu_valid(fu_valid),
        .fu_ready(fu_ready),
        .fu_inst_id(fu_inst_id),
        .rob_valid(rob_valid),
        .rob_inst_id(rob_inst_id)
`ifdef ROB_ARB_PERF_EN
        ,
        .perf_grants(perf_grants),
        .perf_stalls(perf_stalls)
`endif
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = '0;
        fu_inst_id = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        step();
        vec++;
        if (rob_valid !== 2'b00) begin
            err++;
            $display("FAIL reset_valid got %b exp 00", rob_valid);
        end
        vec++;
        if (rob_inst_id !== '0) begin
            err++;
            $display("FAIL reset_id got %h exp 0", rob_inst_id);
        end
        vec++;
        if (fu_ready !== 4'hF) begin
            err++;
            $display("FAIL reset_ready got %b exp 1111", fu_ready);
        end
    endtask

    task automatic test_single;
        do_reset();
        fu_valid = 4'b0100;
        fu_inst_id[2] = 6'd5;
        step();
        fu_valid = '0;
        vec++;
        if (rob_valid !== 2'b00) begin
            err++;
            $display("FAIL single_early got %b exp 00", rob_valid);
        end
        step();
        vec++;
        if (rob_valid !== 2'b01) begin
            err++;
            $display("FAIL single_valid got %b exp 01", rob_valid);
        end
        vec++;
        if (rob_inst_id[0] !== 6'd5 || rob_inst_id[1] !== 6'd0) begin
            err++;
            $display("FAIL single_id got %h exp 005", rob_inst_id);
        end
        step();
        vec++;
        if (rob_valid !== 2'b00) begin
            err++;
            $display("FAIL single_after got %b exp 00", rob_valid);
        end
    endtask

    task automatic test_contention;
        do_reset();
        fu_valid = 4'hF;
        fu_inst_id = {6'd4, 6'd3, 6'd2, 6'd1};
        step();
        fu_valid = '0;
        step();
        vec++;
        if (rob_valid !== 2'b11 || rob_inst_id[0] !== 6'd1 ||
            rob_inst_id[1] !== 6'd2) begin
            err++;
            $display("FAIL cont_c1 got %b %h exp 11 {2,1}",
                     rob_valid, rob_inst_id);
        end
        step();
        vec++;
        if (rob_valid !== 2'b11 || rob_inst_id[0] !== 6'd3 ||
            rob_inst_id[1] !== 6'd4) begin
            err++;
            $display("FAIL cont_c2 got %b %h exp 11 {4,3}",
                     rob_valid, rob_inst_id);
        end
        // rr_ptr should be back at 0: FU0 wins port 0 over FU3
        fu_valid = 4'b1001;
        fu_inst_id[0] = 6'd7;
        fu_inst_id[3] = 6'd8;
        step();
        fu_valid = '0;
        step();
        vec++;
        if (rob_valid !== 2'b11 || rob_inst_id[0] !== 6'd7 ||
            rob_inst_id[1] !== 6'd8) begin
            err++;
            $display("FAIL cont_rr got %b %h exp 11 {8,7}",
                     rob_valid, rob_inst_id);
        end
    endtask

    task automatic test_fairness;
        int p0 [6] = '{10, 30, 21, 12, 32, 23};
        int p1 [6] = '{20, 11, 31, 22, 13, 33};
        do_reset();
        for (int t = 0; t < 7; t++) begin
            if (t < 4) begin
                fu_valid = 4'b1011;
                fu_inst_id[0] = 6'(10 + t);
                fu_inst_id[1] = 6'(20 + t);
                fu_inst_id[3] = 6'(30 + t);
            end else begin
                fu_valid = '0;
            end
            step();
            vec++;
            if (t == 0) begin
                if (rob_valid !== 2'b00) begin
                    err++;
                    $display("FAIL fair_t0 got %b exp 00", rob_valid);
                end
            end else if (rob_valid !== 2'b11 ||
                         rob_inst_id[0] !== 6'(p0[t-1]) ||
                         rob_inst_id[1] !== 6'(p1[t-1])) begin
                err++;
                $display("FAIL fair_t%0d got %b %0d %0d exp 11 %0d %0d",
                         t, rob_valid, rob_inst_id[0],
                         rob_inst_id[1], p0[t-1], p1[t-1]);
            end
        end
        step();
        vec++;
        if (rob_valid !== 2'b00) begin
            err++;
            $display("FAIL fair_end got %b exp 00", rob_valid);
        end
    endtask

    task automatic test_full_ready;
        int n [FC];
        logic [FC-1:0] acc;
        logic [FC-1:0] exp_rdy [4] = '{4'hF, 4'h3, 4'hC, 4'h3};
        do_reset();
        for (int i = 0; i < FC; i++)
            n[i] = 0;
        for (int e = 1; e <= 8; e++) begin
            fu_valid = 4'hF;
            for (int i = 0; i < FC; i++)
                fu_inst_id[i] = 6'(i * 16 + n[i]);
            acc = fu_ready;
            step();
            for (int i = 0; i < FC; i++)
                if (acc[i])
                    n[i]++;
            if (e >= 5) begin
                vec++;
                if (fu_ready !== exp_rdy[e-5]) begin
                    err++;
                    $display("FAIL full_rdy_e%0d got %b exp %b",
                             e, fu_ready, exp_rdy[e-5]);
                end
            end
        end
        vec++;
        if (rob_valid !== 2'b11 || rob_inst_id[0] !== 6'h03 ||
            rob_inst_id[1] !== 6'h13) begin
            err++;
            $display("FAIL full_out got %b %h exp 11 {13,03}",
                     rob_valid, rob_inst_id);
        end
        fu_valid = '0;
    endtask

    task automatic test_flush;
        do_reset();
        fu_valid = 4'b0111;
        fu_inst_id = {6'd0, 6'd3, 6'd2, 6'd1};
        step();
        flush = 1'b1;
        fu_valid = 4'b0001;
        fu_inst_id[0] = 6'd9;
        step();
        flush = 1'b0;
        fu_valid = '0;
        vec++;
        if (rob_valid !== 2'b00) begin
            err++;
            $display("FAIL flush_valid got %b exp 00", rob_valid);
        end
        vec++;
        if (fu_ready !== 4'hF) begin
            err++;
            $display("FAIL flush_ready got %b exp 1111", fu_ready);
        end
        for (int t = 0; t < 3; t++) begin
            step();
            vec++;
            if (rob_valid !== 2'b00) begin
                err++;
                $display("FAIL flush_quiet%0d got %b exp 00",
                         t, rob_valid);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        fu_valid = 4'hF;
        fu_inst_id = {6'd44, 6'd43, 6'd42, 6'd41};
        step();
        step();
        vec++;
        if (rob_valid !== 2'b11) begin
            err++;
            $display("FAIL rmid_pre got %b exp 11", rob_valid);
        end
        rst = 1'b1;
        step();
        vec++;
        if (rob_valid !== 2'b00 || fu_ready !== 4'hF) begin
            err++;
            $display("FAIL rmid_rst got %b %b exp 00 1111",
                     rob_valid, fu_ready);
        end
`ifdef ROB_ARB_PERF_EN
        vec++;
        if (perf_grants !== 32'd0 || perf_stalls !== 32'd0) begin
            err++;
            $display("FAIL rmid_perf got %0d %0d exp 0 0",
                     perf_grants, perf_stalls);
        end
`endif
        rst = 1'b0;
        fu_valid = '0;
        step();
        step();
        vec++;
        if (rob_valid !== 2'b00) begin
            err++;
            $display("FAIL rmid_empty got %b exp 00", rob_valid);
        end
    endtask

    task automatic test_back_to_back;
        int ex [3] = '{40, 41, 42};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if (t < 3) begin
                fu_valid = 4'b0100;
                fu_inst_id[2] = 6'(40 + t);
            end else begin
                fu_valid = '0;
            end
            step();
            if (t >= 1 && t <= 3) begin
                vec++;
                if (rob_valid !== 2'b01 ||
                    rob_inst_id[0] !== 6'(ex[t-1])) begin
                    err++;
                    $display("FAIL b2b_t%0d got %b %0d exp 01 %0d",
                             t, rob_valid, rob_inst_id[0], ex[t-1]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = '0;
        fu_inst_id = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_full_ready();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
